// File: rtl/divisor_sequencial.sv
// Sequential unsigned restoring divider: one trial subtraction per clock through a
// ripple-borrow subtractor, with a start/done handshake and divide-by-zero flag.
module divisor_sequencial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quociente,
    output logic [WIDTH-1:0] resto,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   trial;
    logic             borrow;

    // Ripple-borrow subtractor: trial = rs - {0, D}, borrow-out set when rs < D.
    always_comb begin
        logic bw;
        rs     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        sub_b  = {1'b0, d_q};
        trial  = '0;
        bw     = 1'b0;
        for (int i = 0; i <= WIDTH; i++) begin
            trial[i] = rs[i] ^ sub_b[i] ^ bw;
            bw       = (~rs[i] & sub_b[i]) | (~(rs[i] ^ sub_b[i]) & bw);
        end
        borrow = bw;
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        res_d   = res_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        d_d     = divisor;
                        q_d     = dividendo;
                        r_d     = '0;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = StCalc;
                    end else begin
                        quo_d   = '1;
                        res_d   = dividendo;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StCalc: begin
                q_d   = {q_q[WIDTH-2:0], ~borrow};
                r_d   = borrow ? rs : trial;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    quo_d   = q_d;
                    res_d   = r_d[WIDTH-1:0];
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Status flags are registered from the next state so outputs come straight from flops.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign quociente = quo_q;
    assign resto     = res_q;
    assign div_zero  = dz_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Directed and randomized checks of divisor_sequencial: results, latency, handshake,
// ignored starts and asynchronous reset.
module tb_divisor_sequencial;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividendo;
    logic [W-1:0] divisor;
    logic [W-1:0] quociente;
    logic [W-1:0] resto;
    logic         busy;
    logic         done;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    divisor_sequencial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .quociente (quociente),
        .resto     (resto),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           elat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one division in the current (idle) cycle and checks it through the first idle
    // cycle after done, so consecutive calls run at the maximum issue rate.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic edz, input int elat, input string tag);
        int  lat;
        int  n;
        int  busy_gaps;
        bit  seen;
        dividendo = a;
        divisor   = b;
        start     = 1'b1;
        next_cycle();
        start     = 1'b0;
        dividendo = W'($urandom);
        divisor   = W'($urandom);
        lat       = 0;
        n         = 1;
        busy_gaps = 0;
        seen      = 1'b0;
        while (!seen && n <= int'(W) + 4) begin
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                if (!busy) busy_gaps++;
                next_cycle();
                n++;
            end
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " busy_in_calc"}, busy_gaps, 0);
        chk({tag, " busy_in_done"}, int'(busy), 1);
        chk({tag, " quociente"}, int'(quociente), int'(eq));
        chk({tag, " resto"}, int'(resto), int'(er));
        chk({tag, " div_zero"}, int'(div_zero), int'(edz));
        next_cycle();
        chk({tag, " done_single"}, int'(done), 0);
        chk({tag, " busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int done_cnt;
        int first_done;
        int busy_at10;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'd200, b: 8'd7,   eq: 8'd28,  er: 8'd4,  edz: 1'b0, elat: 9};
        vecs[1] = '{a: 8'd255, b: 8'd1,   eq: 8'd255, er: 8'd0,  edz: 1'b0, elat: 9};
        vecs[2] = '{a: 8'd5,   b: 8'd9,   eq: 8'd0,   er: 8'd5,  edz: 1'b0, elat: 9};
        vecs[3] = '{a: 8'd255, b: 8'd255, eq: 8'd1,   er: 8'd0,  edz: 1'b0, elat: 9};
        vecs[4] = '{a: 8'd77,  b: 8'd0,   eq: 8'hFF,  er: 8'd77, edz: 1'b1, elat: 1};
        vecs[5] = '{a: 8'd10,  b: 8'd3,   eq: 8'd3,   er: 8'd1,  edz: 1'b0, elat: 9};

        rst_n     = 1'b0;
        start     = 1'b0;
        dividendo = '0;
        divisor   = '0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();
        chk("reset quociente", int'(quociente), 0);
        chk("reset resto", int'(resto), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset div_zero", int'(div_zero), 0);

        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].elat,
                    $sformatf("vec%0d", i));
        end

        // 100/3 with start pulsed (9/9) in cycles k+3 and k+9, both must be ignored.
        dividendo = 8'd100;
        divisor   = 8'd3;
        start     = 1'b1;
        next_cycle();
        done_cnt   = 0;
        first_done = 0;
        busy_at10  = 1;
        for (int n = 1; n <= 22; n++) begin
            start     = (n == 3 || n == 9);
            dividendo = 8'd9;
            divisor   = 8'd9;
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end
            if (n == 9) begin
                chk("ignore quociente", int'(quociente), 33);
                chk("ignore resto", int'(resto), 1);
            end
            if (n == 10) busy_at10 = int'(busy);
            next_cycle();
        end
        start = 1'b0;
        chk("ignore done_count", done_cnt, 1);
        chk("ignore done_cycle", first_done, 9);
        chk("ignore busy_after", busy_at10, 0);
        chk("ignore held quociente", int'(quociente), 33);

        // Reset pulsed in cycle k+4 of 200/7.
        dividendo = 8'd200;
        divisor   = 8'd7;
        start     = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst quociente", int'(quociente), 0);
        chk("midrst resto", int'(resto), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst div_zero", int'(div_zero), 0);
        next_cycle();
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            if (done || busy) done_cnt++;
            next_cycle();
        end
        chk("midrst no_activity", done_cnt, 0);
        run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 9, "after_rst");

        for (int i = 0; i < 1000; i++) begin
            rb = W'($urandom_range(0, 255));
            if (i % 10 == 0) rb = '0;
            ra = W'($urandom_range(0, 255));
            if (i % 7 == 0 && rb != '0) ra = W'($urandom_range(0, int'(rb) - 1));
            if (rb == '0) begin
                run_div(ra, rb, '1, ra, 1'b1, 1, $sformatf("rnd%0d", i));
            end else begin
                run_div(ra, rb, ra / rb, ra % rb, 1'b0, int'(W) + 1, $sformatf("rnd%0d", i));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
